mips_cpu_hilo_unit: RTL and testbench

Multi-cycle multiply/divide controller owning the architectural HI/LO registers. The CPU issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to this block instead of the combinational ALU. It sequences a 32-iteration shift-add multiplier and restoring divider sharing one counter, and exposes `busy` so the control unit stalls MFHI/MFLO and further HI/LO ops.

---
 rtl/mips_cpu_pkg.sv | 22 ++
 rtl/mips_cpu_muldiv_step.sv | 38 +++
 rtl/mips_cpu_hilo_unit.sv | 175 +++++++++++++++++
 tb/tb_mips_cpu_hilo_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encodings, FSM states
// and the default operand width.
package mips_cpu_pkg;

  localparam int HILO_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One combinational iteration of the shared multiplier/divider.
// Multiply and divide both consume operand bits MSB first (i_bit).
module mips_cpu_muldiv_step
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_bit,
  input  logic               i_is_div,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // Restoring divide: the remainder borrow bit decides the quotient bit.
  // Multiply: shift the partial product left and add the multiplicand.
  always_comb begin
    w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_bit};
    w_diff   = w_rem_sh - {1'b0, i_operand};
    w_ge     = ~w_diff[WIDTH];
    if (i_is_div) begin
      if (w_ge) begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else if (i_bit) begin
      o_acc = {i_acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, i_operand};
    end else begin
      o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO controller owning the HI/LO
// registers; busy stalls the CPU while an arithmetic op is in flight.
module mips_cpu_hilo_unit
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH-1);

  hilo_state_t        r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_sa;
  logic               r_sb;
  logic               r_is_div;
  logic               r_done;

  logic               w_arith;
  logic               w_signed;
  logic               w_is_div;
  logic               w_div_zero;
  logic               w_bit;
  logic [CW-1:0]      w_idx;
  logic [WIDTH-1:0]   w_operand;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_step_acc;

  // |0x80000000| wraps back to 0x80000000, which is the right unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // Decode the issued op.
  always_comb begin
    w_arith  = 1'b0;
    w_signed = 1'b0;
    w_is_div = 1'b0;
    case (i_op)
      OP_MULT:  begin w_arith = 1'b1; w_signed = 1'b1; end
      OP_MULTU: begin w_arith = 1'b1; end
      OP_DIV:   begin w_arith = 1'b1; w_signed = 1'b1; w_is_div = 1'b1; end
      OP_DIVU:  begin w_arith = 1'b1; w_is_div = 1'b1; end
      default:  begin w_arith = 1'b0; end
    endcase
    w_div_zero = w_is_div && (i_b == {WIDTH{1'b0}});
  end

  assign w_idx     = LAST_CNT - r_cnt;
  assign w_bit     = r_is_div ? r_mag_a[w_idx] : r_mag_b[w_idx];
  assign w_operand = r_is_div ? r_mag_b : r_mag_a;

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (w_operand),
    .i_bit     (w_bit),
    .i_is_div  (r_is_div),
    .o_acc     (w_step_acc)
  );

  // Sign correction applied in FIX; divide-by-zero clears both sign flags.
  always_comb begin
    w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    if (r_is_div) begin
      w_fix_lo = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_fix_hi = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_fix_lo = w_prod[WIDTH-1:0];
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // FSM, iteration counter, operand latches and HI/LO commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mag_a  <= {WIDTH{1'b0}};
      r_mag_b  <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_flush) begin
            if (i_op == OP_MTHI) begin
              r_hi <= i_a;
            end else if (i_op == OP_MTLO) begin
              r_lo <= i_a;
            end else if (w_arith) begin
              r_cnt    <= {CW{1'b0}};
              r_is_div <= w_is_div;
              r_mag_a  <= f_mag(i_a, w_signed);
              r_mag_b  <= f_mag(i_b, w_signed);
              if (w_div_zero) begin
                r_acc   <= {i_a, {WIDTH{1'b1}}};
                r_sa    <= 1'b0;
                r_sb    <= 1'b0;
                r_state <= S_FIX;
              end else begin
                r_acc   <= {(2*WIDTH){1'b0}};
                r_sa    <= w_signed & i_a[WIDTH-1];
                r_sb    <= w_signed & i_b[WIDTH-1];
                r_state <= S_CALC;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!i_flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end else begin
            r_done <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Self-checking bench for mips_cpu_hilo_unit: directed test-plan cases plus
// randomized traffic, all compared every cycle against a cycle-count model.
module tb_mips_cpu_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mips_cpu_hilo_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} computed with plain integer arithmetic.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = 64'd0;
    case (o)
      3'd0: p = sx * sy;
      3'd1: p = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else p = {x % y, x / y};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Model: an accepted arithmetic op keeps the unit busy for a fixed number
  // of cycles, then commits its result and raises done for one cycle.
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  int          m_left;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_res_hi <= 32'd0; m_res_lo <= 32'd0;
      m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= m_res_hi; m_lo <= m_res_lo; m_done <= 1'b1;
          end
        end
      end else if (start && !flush) begin
        case (op)
          3'd4: m_hi <= a;
          3'd5: m_lo <= a;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {m_res_hi, m_res_lo} <= ref_calc(op, a, b);
            m_left <= (op >= 3'd2 && b == 32'd0) ? 1 : 33;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", {63'd0, busy}, {63'd0, (m_left != 0)});
    check("cyc_done", {63'd0, done}, {63'd0, m_done});
    check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
    check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_idle(name);
    check({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int bc, dc;
    check("ref_multu", ref_calc(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    check("ref_mult", ref_calc(3'd0, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    check("ref_div", ref_calc(3'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    check("ref_divovf", ref_calc(3'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    check("ref_div0", ref_calc(3'd2, 32'd5, 32'd0), 64'h00000005_FFFFFFFF);

    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    rst_n = 1'b1;

    // MULTU max: busy exactly 33 cycles, one done pulse.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) dc++;
      @(negedge clk);
    end
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_done_pulses", 64'(dc), 64'd1);
    check("multu_hi", {32'd0, hi}, 64'hFFFFFFFE);
    check("multu_lo", {32'd0, lo}, 64'h00000001);

    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);

    // Back-to-back: issue while done is high.
    check("b2b_done", {63'd0, done}, 64'd1);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted", {63'd0, busy}, 64'd1);
    wait_idle("b2b");
    check("b2b_lo", {32'd0, lo}, 64'd15);
    check("b2b_hi", {32'd0, hi}, 64'd0);

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Divide by zero: FIX for one cycle, done in the second cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check("div0_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("div0_done", {63'd0, done}, 64'd1);
    check("div0_hi", {32'd0, hi}, 64'd5);
    check("div0_lo", {32'd0, lo}, 64'hFFFFFFFF);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    check("mtlo_busy", {63'd0, busy}, 64'd0);

    // MTHI while a MULT is in flight is ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFD; b = 32'd7;
    @(negedge clk);
    op = 3'd4; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mthi_busy_ign");
    check("mthi_ign_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("mthi_ign_lo", {32'd0, lo}, 64'hFFFFFFEB);

    // Flush during the 10th CALC cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("flush_lo", {32'd0, lo}, 64'hFFFFFFEB);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, including starts while busy and stray flushes.
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = rnd_operand();
      b     = rnd_operand();
      flush = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
